pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
//
// PURPOSE
//  Program-counter register and next-PC sequencer for the core fetch stage.
//  Holds the 11-bit PC and each cycle selects the next PC:
//    sequential increment, PC-relative branch, absolute jump, call (push return) or return (pop).
//  The Adder_10bit instances produce the sum; this block registers it and owns the
//  return-address stack that reads the increments back.
//
// PARAMETERS
//  PC_W          11      PC width in bits; all PC arithmetic is modulo 2**PC_W
//  RESET_VECTOR  11'h000 PC value loaded at reset
//  RAS_DEPTH     4       return-address stack entries (power of 2, >= 2)
//
// PORTS
//  clk             in   1     core clock; all state updates on rising edge
//  rst_n           in   1     asynchronous active-low reset
//  stall           in   1     1 = hold PC and stack; all other requests ignored
//  branch_taken    in   1     PC-relative branch request
//  branch_offset   in   PC_W  two's-complement offset added to current PC
//  jump            in   1     absolute jump request
//  call            in   1     absolute call request: push PC+1, go to target
//  ret             in   1     return request: pop stack into PC
//  target          in   PC_W  absolute destination for jump/call
//  pc              out  PC_W  current PC (registered)
//  ras_empty       out  1     stack holds 0 entries (combinational from count)
//  ras_overflow    out  1     sticky: a call was pushed while stack full
//  ras_underflow   out  1     sticky: a ret was issued while stack empty
//
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc=RESET_VECTOR, stack count=0, ras_empty=1, sticky flags=0.
//    Reset mid-operation discards all stack contents; no request is partially applied.
//  - Latency: one cycle. A request sampled at edge N appears on pc after edge N.
//  - Next-PC priority when stall=0, highest first:
//      ret > call > jump > branch_taken > increment.
//    Lower-priority requests in the same cycle are ignored entirely (no push/pop side effects).
//  - increment: pc <= pc + 1.    branch: pc <= pc + branch_offset.
//  - jump: pc <= target.         call: push (pc + 1), pc <= target.
//  - ret, count>0: pc <= top entry, count--.
//  - ret, count==0: pc <= pc + 1, ras_underflow <= 1, count stays 0.
//  - call with count==RAS_DEPTH: oldest entry is overwritten (circular stack),
//    count stays RAS_DEPTH, ras_overflow <= 1. Later pops return the newest RAS_DEPTH addresses.
//  - Wrap-around: all sums are truncated to PC_W bits, no carry out or exception.
//    Examples: 11'h7FF+1 -> 11'h000; pc=11'h002 with offset 11'h7FC (-4) -> 11'h7FE.
//  - stall=1 overrides everything: pc, stack, count and flags hold. Requests are not queued.
//  - Sticky flags clear only on reset.
//
// STRUCTURE
//  - Shared package/header: PC_W, RESET_VECTOR default, and the next-PC select encoding
//    SEL_INC, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET, so the decode/control unit can share it.
//  - Two Adder_10bit instances: (pc, 1) and (pc, branch_offset). No new adder logic.
//  - One sub-module, pc_return_stack:
//      circular buffer with push, pop, push_data, top, count, full, empty.
//    pc_sequencer holds only the PC register, the priority mux and the sticky flags.
//
// TESTING
//  1. Reset then 3 idle cycles -> pc = 000, 001, 002, 003; ras_empty=1; flags=0.
//  2. pc=7FE, 2 idle cycles -> pc = 7FF then 000 (wrap).
//     pc=010 with branch_offset=7F8 -> pc=008.
//  3. At pc=020, call target=100; ret 2 cycles later -> pc = 100, 101, then 021; ras_empty=1.
//  4. RAS_DEPTH+1 nested calls from pc=000,001,002,...; then RAS_DEPTH+1 rets.
//     -> ras_overflow=1; pops return newest RAS_DEPTH addresses, then ras_underflow=1.
//  5. At pc=040, assert call, jump and branch_taken together with stall=1 for 2 cycles,
//     then stall=0 -> pc holds 040 for 2 cycles, then pc=target; exactly one push.
//  6. Pulse rst_n low mid-cycle with 2 stack entries -> pc=RESET_VECTOR immediately (no clock),
//     ras_empty=1; a following ret raises ras_underflow.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: PC width, reset vector and next-PC select encoding shared with decode/control.
package pc_sequencer_pkg;
  localparam int PC_W = 11;
  localparam logic [PC_W-1:0] RESET_VECTOR = 11'h000;
  localparam logic [2:0] SEL_INC = 3'd0;
  localparam logic [2:0] SEL_BR = 3'd1;
  localparam logic [2:0] SEL_JMP = 3'd2;
  localparam logic [2:0] SEL_CALL = 3'd3;
  localparam logic [2:0] SEL_RET = 3'd4;
endpackage

// File: rtl/Adder_10bit.sv
// Adder_10bit: plain width-parameterised adder, sum truncated to W bits.
module Adder_10bit #(
  parameter int W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/pc_return_stack.sv
// pc_return_stack: circular return-address stack; a push when full overwrites the oldest entry.
module pc_return_stack #(
  parameter int W = 11,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               push_data,
  output logic [W-1:0]               top,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] ptr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign top = mem[ptr - AW'(1)];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + AW'(1);
      count <= full ? count : count + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr - AW'(1);
      count <= count - 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[ptr] <= push_data;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register with ret > call > jump > branch > increment next-PC selection
// and sticky return-stack overflow/underflow flags.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = pc_sequencer_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_VECTOR = pc_sequencer_pkg::RESET_VECTOR,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_offset,
  input  logic            jump,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc,
  output logic            ras_empty,
  output logic            ras_overflow,
  output logic            ras_underflow
);
  logic [PC_W-1:0] pc_inc, pc_br, top, pc_next;
  logic [$clog2(RAS_DEPTH):0] count;
  logic full, empty, push, pop;
  logic [2:0] sel;
  Adder_10bit #(.W(PC_W)) u_inc (.a(pc), .b(PC_W'(1)), .sum(pc_inc));
  Adder_10bit #(.W(PC_W)) u_br (.a(pc), .b(branch_offset), .sum(pc_br));
  pc_return_stack #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .push_data(pc_inc),
    .top(top), .count(count), .full(full), .empty(empty)
  );
  always_comb begin
    sel = ret ? SEL_RET : call ? SEL_CALL : jump ? SEL_JMP : branch_taken ? SEL_BR : SEL_INC;
    push = !stall && sel == SEL_CALL;
    pop = !stall && sel == SEL_RET && !empty;
    pc_next = sel == SEL_RET ? (empty ? pc_inc : top) :
              (sel == SEL_CALL || sel == SEL_JMP) ? target :
              sel == SEL_BR ? pc_br : pc_inc;
  end
  assign ras_empty = count == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VECTOR;
      ras_overflow <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (!stall) begin
      pc <= pc_next;
      if (push && full) ras_overflow <= 1'b1;
      if (sel == SEL_RET && empty) ras_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus pushes expected PC/flags into a queue; a monitor pops and compares.
module tb_pc_sequencer;
  logic clk = 0, rst_n = 0, stall = 0, branch_taken = 0, jump = 0, call = 0, ret = 0;
  logic [10:0] branch_offset = '0, target = '0, pc;
  logic ras_empty, ras_overflow, ras_underflow;
  int passed = 0, total = 0;
  typedef struct {
    logic [10:0] pc;
    logic e, o, u;
    string name;
  } exp_t;
  exp_t q[$];

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .call(call), .ret(ret), .target(target),
    .pc(pc), .ras_empty(ras_empty), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input exp_t x);
    total++;
    if (pc === x.pc && ras_empty === x.e && ras_overflow === x.o && ras_underflow === x.u) passed++;
    else $display("FAIL %s: got pc=%h empty=%b ovf=%b unf=%b, expected pc=%h empty=%b ovf=%b unf=%b",
                  x.name, pc, ras_empty, ras_overflow, ras_underflow, x.pc, x.e, x.o, x.u);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() > 0) check(q.pop_front());
  end

  task automatic step(input logic s, r, c, j, b, input logic [10:0] tgt, off,
                      input logic [10:0] epc, input logic ee, eo, eu, input string name);
    exp_t x;
    stall = s; ret = r; call = c; jump = j; branch_taken = b; target = tgt; branch_offset = off;
    x.pc = epc; x.e = ee; x.o = eo; x.u = eu; x.name = name;
    q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  initial begin
    exp_t x;
    #1;
    x.pc = 11'h000; x.e = 1; x.o = 0; x.u = 0; x.name = "reset";
    check(x);
    @(posedge clk);
    #2 rst_n = 1;
    // idle increments
    step(0,0,0,0,0, 0, 0, 11'h001, 1,0,0, "inc1");
    step(0,0,0,0,0, 0, 0, 11'h002, 1,0,0, "inc2");
    step(0,0,0,0,0, 0, 0, 11'h003, 1,0,0, "inc3");
    // wrap and negative branch
    step(0,0,0,1,0, 11'h7FE, 0, 11'h7FE, 1,0,0, "jmp7fe");
    step(0,0,0,0,0, 0, 0, 11'h7FF, 1,0,0, "inc7ff");
    step(0,0,0,0,0, 0, 0, 11'h000, 1,0,0, "wrap");
    step(0,0,0,1,0, 11'h010, 0, 11'h010, 1,0,0, "jmp010");
    step(0,0,0,0,1, 0, 11'h7F8, 11'h008, 1,0,0, "br_neg");
    // call/ret round trip
    step(0,0,0,1,0, 11'h020, 0, 11'h020, 1,0,0, "jmp020");
    step(0,0,1,0,0, 11'h100, 0, 11'h100, 0,0,0, "call100");
    step(0,0,0,0,0, 0, 0, 11'h101, 0,0,0, "inc101");
    step(0,1,0,0,0, 0, 0, 11'h021, 1,0,0, "ret021");
    // overflow then underflow
    step(0,0,0,1,0, 11'h000, 0, 11'h000, 1,0,0, "jmp000");
    step(0,0,1,0,0, 11'h001, 0, 11'h001, 0,0,0, "call1");
    step(0,0,1,0,0, 11'h002, 0, 11'h002, 0,0,0, "call2");
    step(0,0,1,0,0, 11'h003, 0, 11'h003, 0,0,0, "call3");
    step(0,0,1,0,0, 11'h004, 0, 11'h004, 0,0,0, "call4");
    step(0,0,1,0,0, 11'h005, 0, 11'h005, 0,1,0, "call5_ovf");
    step(0,1,0,0,0, 0, 0, 11'h005, 0,1,0, "pop005");
    step(0,1,0,0,0, 0, 0, 11'h004, 0,1,0, "pop004");
    step(0,1,0,0,0, 0, 0, 11'h003, 0,1,0, "pop003");
    step(0,1,0,0,0, 0, 0, 11'h002, 1,1,0, "pop002");
    step(0,1,0,0,0, 0, 0, 11'h003, 1,1,1, "ret_unf");
    // stall with several requests, then release
    step(0,0,0,1,0, 11'h040, 0, 11'h040, 1,1,1, "jmp040");
    step(1,0,1,1,1, 11'h123, 11'h005, 11'h040, 1,1,1, "stall1");
    step(1,0,1,1,1, 11'h123, 11'h005, 11'h040, 1,1,1, "stall2");
    step(0,0,1,1,1, 11'h123, 11'h005, 11'h123, 0,1,1, "call123");
    step(0,1,0,0,0, 0, 0, 11'h041, 1,1,1, "ret041");
    step(0,1,0,0,0, 0, 0, 11'h042, 1,1,1, "single_push");
    // asynchronous reset with two live entries
    step(0,0,1,0,0, 11'h200, 0, 11'h200, 0,1,1, "call200");
    step(0,0,1,0,0, 11'h300, 0, 11'h300, 0,1,1, "call300");
    call = 0;
    #2 rst_n = 0;
    #1;
    x.pc = 11'h000; x.e = 1; x.o = 0; x.u = 0; x.name = "async_rst";
    check(x);
    #1 rst_n = 1;
    step(0,1,0,0,0, 0, 0, 11'h001, 1,0,1, "ret_after_rst");
    step(0,0,0,0,0, 0, 0, 11'h002, 1,0,1, "inc_after_rst");
    ret = 0;
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
